// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter and fetch-sequencing stage.
//
// Picks the next PC from the sequential, branch, jump and jump-register sources.
// Drives the instruction-memory fetch request and holds the PC while fetch
// cannot advance. A redirect that arrives while fetch is blocked is latched and
// applied on the next advance. Loading a redirect target raises a one-cycle
// IF/ID flush.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   stall_i             hazard hold; PC must not advance
//   branch_taken_i      taken-branch request, target branch_target_i
//   jump_i              j/jal request, 26-bit index jump_target_i
//   jr_i                jr request, target jr_addr_i
//   imem_ready_i        instruction memory accepts the current fetch
//   pc_o, pc_plus4_o    current fetch address and pc_o + 4 (wraps)
//   fetch_valid_o       pc_o is a valid fetch request
//   flush_o             kill the IF/ID instruction this cycle
//   pending_o           a latched redirect is waiting
//   misalign_o          (PC_ALIGN_CHECK_EN only) sticky misaligned-target flag
//
// Build option
//   PC_ALIGN_CHECK_EN   if defined, a misaligned redirect target halts fetch
//                       until reset. If undefined, target bits [1:0] are
//                       cleared before use.
//
// State | meaning
// WAIT  | post-reset delay, no fetch, redirects ignored
// RUN   | fetching, redirects taken directly or latched
// PEND  | fetching, a latched redirect waits for an advance
// HALT  | misaligned target seen, fetch stopped until reset

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned RESET_WAIT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_valid_o,
    output logic        flush_o,
`ifdef PC_ALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        pending_o
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_WAIT, ST_RUN, ST_PEND, ST_HALT} state_t;
`else
    typedef enum logic [1:0] {ST_WAIT, ST_RUN, ST_PEND} state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic [3:0]  wait_q;
    logic        valid_q;
    logic        pending_q;
    logic        adv;
    logic        req;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;
    logic        flush_d;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_q;
    logic        tgt_misaligned;
`endif

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + 32'd4;
    assign fetch_valid_o = valid_q;
    assign pending_o     = pending_q;
    assign flush_o       = flush_d;

    assign adv = valid_q & imem_ready_i & ~stall_i;
    assign req = jr_i | jump_i | branch_taken_i;

    always_comb begin
        tgt_raw = branch_target_i;
        if (jr_i) begin
            tgt_raw = jr_addr_i;
        end else if (jump_i) begin
            tgt_raw = {pc_plus4_o[31:28], jump_target_i, 2'b00};
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign tgt            = tgt_raw;
    assign tgt_misaligned = |tgt_raw[1:0];
    assign misalign_o     = misalign_q;
`else
    assign tgt = tgt_raw & ~32'h3;
`endif

    always_comb begin
        flush_d = 1'b0;
        case (state_q)
            ST_RUN: begin
`ifdef PC_ALIGN_CHECK_EN
                // A misaligned target halts at once, even without an advance.
                if (req && tgt_misaligned) flush_d = 1'b1;
                else
`endif
                if (req && adv) flush_d = 1'b1;
            end
            ST_PEND: flush_d = adv;
            default: flush_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_WAIT;
            pc_q      <= RESET_PC;
            pend_q    <= 32'h0;
            wait_q    <= 4'(RESET_WAIT);
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_WAIT: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q <= 4'd1) begin
                        state_q <= ST_RUN;
                        valid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef PC_ALIGN_CHECK_EN
                    if (req && tgt_misaligned) begin
                        state_q    <= ST_HALT;
                        valid_q    <= 1'b0;
                        misalign_q <= 1'b1;
                    end else
`endif
                    if (req && adv) begin
                        pc_q <= tgt;
                    end else if (req) begin
                        pend_q    <= tgt;
                        pending_q <= 1'b1;
                        state_q   <= ST_PEND;
                    end else if (adv) begin
                        pc_q <= pc_plus4_o;
                    end
                end
                ST_PEND: begin
                    if (adv) begin
                        pc_q      <= pend_q;
                        pending_q <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                end
                default: begin
                    // HALT: hold everything until reset
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        jump_i = 1'b0;
    logic [25:0] jump_target_i = '0;
    logic        jr_i = 1'b0;
    logic [31:0] jr_addr_i = '0;
    logic        imem_ready_i = 1'b1;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        pending_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .RESET_WAIT(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .jr_i(jr_i), .jr_addr_i(jr_addr_i), .imem_ready_i(imem_ready_i),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .fetch_valid_o(fetch_valid_o),
        .flush_o(flush_o),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_o(misalign_o),
`endif
        .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic clear_in();
        stall_i = 0; branch_taken_i = 0; jump_i = 0; jr_i = 0;
        imem_ready_i = 1;
    endtask

    // One clock: move to next falling edge, outputs settle 1 unit later.
    task automatic tick();
        @(negedge clk_i);
    endtask

    // Redirect via jr so the later scenarios start from a known PC.
    task automatic goto_pc(input logic [31:0] a);
        clear_in(); jr_i = 1; jr_addr_i = a;
        tick();
        jr_i = 0;
    endtask

    task automatic hard_reset();
        clear_in(); rst_i = 1;
        tick();
        rst_i = 0;
        tick(); tick(); #1;
    endtask

    task automatic test_reset();
        clear_in(); rst_i = 1;
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 00000000", pc_o); end
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", fetch_valid_o); end
        n_cmp++; if (pending_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_pend_flush got %b%b want 00", pending_o, flush_o); end
        tick(); rst_i = 0; #1;
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL wait0_valid got %b want 0", fetch_valid_o); end
        tick(); #1;
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL wait1_valid got %b want 0", fetch_valid_o); end
        tick(); #1;
        n_cmp++; if (fetch_valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL first_fetch got v=%b pc=%h want v=1 pc=00000000", fetch_valid_o, pc_o); end
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL seq_pc4 got %h want 00000004", pc_o); end
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h8) begin n_fail++; $display("FAIL seq_pc8 got %h want 00000008", pc_o); end
        n_cmp++; if (pc_plus4_o !== 32'hC) begin n_fail++; $display("FAIL pc_plus4 got %h want 0000000c", pc_plus4_o); end
    endtask

    task automatic test_branch();
        tick(); tick(); #1;
        n_cmp++; if (pc_o !== 32'h10) begin n_fail++; $display("FAIL br_start got %h want 00000010", pc_o); end
        branch_taken_i = 1; branch_target_i = 32'h40; #1;
        n_cmp++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL br_flush got %b want 1", flush_o); end
        tick(); branch_taken_i = 0; #1;
        n_cmp++; if (pc_o !== 32'h40 || flush_o !== 1'b0) begin n_fail++; $display("FAIL br_target got pc=%h f=%b want 00000040 f=0", pc_o, flush_o); end
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h44) begin n_fail++; $display("FAIL br_next got %h want 00000044", pc_o); end
    endtask

    task automatic test_stall_jump();
        goto_pc(32'h20);
        stall_i = 1; jump_i = 1; jump_target_i = 26'h000100; #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL sj_noflush got %b want 0", flush_o); end
        tick(); jump_i = 0; #1;
        n_cmp++; if (pending_o !== 1'b1 || pc_o !== 32'h20) begin n_fail++; $display("FAIL sj_pend got p=%b pc=%h want p=1 pc=00000020", pending_o, pc_o); end
        tick(); #1;
        n_cmp++; if (pending_o !== 1'b1 || pc_o !== 32'h20 || flush_o !== 1'b0) begin n_fail++; $display("FAIL sj_hold got p=%b pc=%h f=%b want 1 00000020 0", pending_o, pc_o, flush_o); end
        stall_i = 0; #1;
        n_cmp++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL sj_flush got %b want 1", flush_o); end
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h400 || pending_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL sj_load got pc=%h p=%b f=%b want 00000400 0 0", pc_o, pending_o, flush_o); end
    endtask

    task automatic test_priority();
        goto_pc(32'h100);
        jr_i = 1; jr_addr_i = 32'h80; jump_i = 1; jump_target_i = 26'h3;
        branch_taken_i = 1; branch_target_i = 32'h40; #1;
        n_cmp++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL pri_flush got %b want 1", flush_o); end
        tick(); clear_in(); #1;
        n_cmp++; if (pc_o !== 32'h80 || flush_o !== 1'b0 || pending_o !== 1'b0) begin n_fail++; $display("FAIL pri_pc got pc=%h f=%b p=%b want 00000080 0 0", pc_o, flush_o, pending_o); end
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h84 || flush_o !== 1'b0) begin n_fail++; $display("FAIL pri_next got pc=%h f=%b want 00000084 0", pc_o, flush_o); end
    endtask

    task automatic test_ready_wrap();
        goto_pc(32'h30);
        imem_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_cmp++; if (pc_o !== 32'h30) begin n_fail++; $display("FAIL rdy_hold%0d got %h want 00000030", i, pc_o); end
        end
        imem_ready_i = 1;
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h34) begin n_fail++; $display("FAIL rdy_resume got %h want 00000034", pc_o); end
        goto_pc(32'hFFFF_FFFC); #1;
        n_cmp++; if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin n_fail++; $display("FAIL wrap_pre got pc=%h p4=%h want fffffffc 00000000", pc_o, pc_plus4_o); end
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL wrap got %h want 00000000", pc_o); end
    endtask

    task automatic test_reset_pend();
        goto_pc(32'h40);
        stall_i = 1; jump_i = 1; jump_target_i = 26'h40;
        tick(); jump_i = 0; #1;
        n_cmp++; if (pending_o !== 1'b1) begin n_fail++; $display("FAIL rp_pend got %b want 1", pending_o); end
        #2 rst_i = 1; #1;
        n_cmp++; if (pc_o !== 32'h0 || pending_o !== 1'b0 || fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL rp_async got pc=%h p=%b v=%b want 00000000 0 0", pc_o, pending_o, fetch_valid_o); end
        tick(); rst_i = 0; stall_i = 0;
        tick(); tick(); #1;
        n_cmp++; if (pc_o !== 32'h0 || fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL rp_restart got pc=%h v=%b want 00000000 1", pc_o, fetch_valid_o); end
        tick(); #1;
        n_cmp++; if (pc_o !== 32'h4 || pending_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL rp_discard got pc=%h p=%b f=%b want 00000004 0 0", pc_o, pending_o, flush_o); end
    endtask

`ifdef PC_ALIGN_CHECK_EN
    task automatic test_misalign();
        hard_reset();
        goto_pc(32'h10);
        jr_i = 1; jr_addr_i = 32'h82; #1;
        n_cmp++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL mis_flush got %b want 1", flush_o); end
        tick(); jr_i = 0; #1;
        n_cmp++; if (misalign_o !== 1'b1 || fetch_valid_o !== 1'b0 || pc_o !== 32'h10) begin n_fail++; $display("FAIL mis_halt got m=%b v=%b pc=%h want 1 0 00000010", misalign_o, fetch_valid_o, pc_o); end
        tick(); tick(); #1;
        n_cmp++; if (misalign_o !== 1'b1 || fetch_valid_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL mis_stay got m=%b v=%b f=%b want 1 0 0", misalign_o, fetch_valid_o, flush_o); end
        rst_i = 1; #1;
        n_cmp++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_reset got %b want 0", misalign_o); end
        tick(); rst_i = 0;
    endtask
`endif

    // Reference: PC is a number, the post-reset delay a countdown of edges,
    // and the latched redirect a queue of at most one address.
    task automatic test_random();
        logic [31:0] m_pc;
        int          m_wait;
        logic [31:0] m_pend[$];
        logic [31:0] tgt;
        logic [31:0] e_p4;
        bit          v, adv, req, e_flush;
        clear_in(); rst_i = 1;
        tick(); rst_i = 0;
        m_pc = 32'h0; m_wait = 2; m_pend.delete();
        for (int c = 0; c < 600; c++) begin
            stall_i        = ($urandom_range(0, 3) == 0);
            imem_ready_i   = ($urandom_range(0, 4) != 0);
            branch_taken_i = ($urandom_range(0, 5) == 0);
            jump_i         = ($urandom_range(0, 7) == 0);
            jr_i           = ($urandom_range(0, 7) == 0);
            branch_target_i = $urandom;
            jump_target_i   = 26'($urandom);
            jr_addr_i       = $urandom;
`ifdef PC_ALIGN_CHECK_EN
            branch_target_i[1:0] = 2'b00;
            jr_addr_i[1:0]       = 2'b00;
`endif
            #1;
            v   = (m_wait == 0);
            adv = v && imem_ready_i && !stall_i;
            req = jr_i || jump_i || branch_taken_i;
            e_p4 = m_pc + 32'd4;
            if (jr_i)        tgt = jr_addr_i;
            else if (jump_i) tgt = {e_p4[31:28], jump_target_i, 2'b00};
            else             tgt = branch_target_i;
            tgt = tgt & 32'hFFFF_FFFC;
            e_flush = adv && (m_pend.size() > 0 || req);
            n_cmp++; if (pc_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got %h want %h", c, pc_o, m_pc); end
            n_cmp++; if (pc_plus4_o !== e_p4) begin n_fail++; $display("FAIL rnd_p4 c=%0d got %h want %h", c, pc_plus4_o, e_p4); end
            n_cmp++; if (fetch_valid_o !== v) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, fetch_valid_o, v); end
            n_cmp++; if (pending_o !== (m_pend.size() > 0)) begin n_fail++; $display("FAIL rnd_pend c=%0d got %b want %b", c, pending_o, m_pend.size() > 0); end
            n_cmp++; if (flush_o !== e_flush) begin n_fail++; $display("FAIL rnd_flush c=%0d got %b want %b", c, flush_o, e_flush); end
            if (!v)                  m_wait--;
            else if (m_pend.size() > 0) begin
                if (adv) m_pc = m_pend.pop_front();
            end
            else if (req && adv)     m_pc = tgt;
            else if (req)            m_pend.push_back(tgt);
            else if (adv)            m_pc = e_p4;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_jump();
        test_priority();
        test_ready_wrap();
        test_reset_pend();
`ifdef PC_ALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-sequencing stage; sits directly downstream of the branch-decision logic and consumes its single-bit taken signal.
- Selects next PC from sequential, branch, jump and jump-register sources.
- Drives the instruction-memory fetch handshake and holds the PC on stalls.
- Latches redirects that arrive while fetch cannot advance, and emits the IF/ID flush pulse.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
RESET_WAIT, 2, cycles after reset release before first fetch_valid_o (range 1..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
stall_i  in  1  hazard-unit hold request; PC must not advance
branch_taken_i  in  1  taken-branch decision from branch control
branch_target_i  in  32  branch target address
jump_i  in  1  j/jal redirect request
jump_target_i  in  26  instruction index field
jr_i  in  1  jr redirect request
jr_addr_i  in  32  register value for jr
imem_ready_i  in  1  instruction memory accepts the current fetch
pc_o  out  32  current fetch address
pc_plus4_o  out  32  pc_o + 4, combinational, wraps modulo 2^32
fetch_valid_o  out  1  pc_o is a valid fetch request
flush_o  out  1  kill the instruction in IF/ID this cycle
pending_o  out  1  a latched redirect is waiting

Behaviour:
- Clock and reset:
  - One clock, clk_i. Reset is asynchronous and active-high on rst_i.
  - Reset values: pc_o=RESET_PC, fetch_valid_o=0, flush_o=0, pending_o=0, pend_q=0, wait counter=RESET_WAIT, state=WAIT.
- Advance condition: adv = fetch_valid_o & imem_ready_i & ~stall_i.
- Redirect priority: jr_i > jump_i > branch_taken_i. req = jr_i | jump_i | branch_taken_i.
- Target selection:
  - jr: jr_addr_i.
  - jump: {pc_plus4_o[31:28], jump_target_i, 2'b00}.
  - branch: branch_target_i.
- States:
  - WAIT:
    - fetch_valid_o=0; counter decrements each cycle; redirect inputs ignored.
    - On counter==1, go to RUN. First fetch_valid_o is asserted RESET_WAIT cycles after reset deassertion.
  - RUN:
    - fetch_valid_o=1.
    - req & adv: pc_o <= target; flush_o=1 in this same cycle (combinational); stay in RUN.
    - req & ~adv: pend_q <= target; go to PEND; flush_o=0; pc_o held.
    - ~req & adv: pc_o <= pc_plus4_o.
    - ~req & ~adv: pc_o held.
  - PEND:
    - fetch_valid_o=1, pending_o=1; new req inputs ignored.
    - adv: pc_o <= pend_q; flush_o=1; go to RUN.
    - ~adv: hold.
- pc_o changes only on adv; no advance ever occurs when imem_ready_i=0.
- flush_o is never asserted outside a cycle in which pc_o is loaded with a redirect target; it is exactly 1 cycle wide per redirect.
- Wrap-around: sequential PC 32'hFFFF_FFFC advances to 32'h0000_0000.
- Reset mid-operation (any state, any pending target): asynchronous return to reset values; the pending redirect is discarded.
- Simultaneous jr_i, jump_i and branch_taken_i: jr target wins; the others are dropped, not queued.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A selected redirect target with [1:0]!=0 is not loaded. Instead misalign_o is set sticky, state goes to HALT, fetch_valid_o=0, flush_o=1 for that cycle.
  - HALT is left only by reset.
- When undefined:
  - Target bits [1:0] are forced to 2'b00 before loading or latching; no misalign_o port; no HALT state.

Test Plan:
- Reset, RESET_WAIT=2, imem_ready_i=1 -> fetch_valid_o low for 2 cycles after rst_i falls; then pc_o=0, 4, 8 on successive cycles.
- At pc_o=0x10, assert branch_taken_i with branch_target_i=0x40 for 1 cycle -> flush_o=1 that cycle; next pc_o=0x40; then 0x44.
- At pc_o=0x20, stall_i=1 plus jump_i with jump_target_i=0x000100 -> pending_o=1, pc_o stays 0x20; stall_i drops -> flush_o=1, pc_o=0x0000_0400, pending_o=0.
- jr_i (jr_addr_i=0x80), jump_i and branch_taken_i (0x40) all asserted together with adv -> pc_o=0x80; single flush pulse.
- imem_ready_i=0 for 3 cycles at pc_o=0x30 -> pc_o holds 0x30; ready returns -> 0x34. Then pc_o=0xFFFF_FFFC with adv -> 0x0.
- rst_i pulsed while in PEND (pend_q=0x100) -> pc_o=RESET_PC and pending_o=0 immediately. With PC_ALIGN_CHECK_EN, a jr to 0x82 -> misalign_o=1 and fetch_valid_o=0 until reset.
